adc_spi_capture: RTL and testbench

Serial ADC front-end that produces the 12-bit `data_adc` word consumed by the SoC's APB ADC slave. It periodically runs one SPI read frame on an external serial ADC (CS_n / SCLK / SDATA, MSB first) and extracts the data field. It then presents the result as a registered parallel word with a one-cycle valid strobe. It sits between the chip pins and the `data_adc` input of `CortexM0_SoC`.

---
 rtl/adc_spi_capture.sv | 165 ++++++++++++++++
 tb/tb_adc_spi_capture.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_capture.sv
// Serial ADC front-end: periodically runs one SPI read frame (CPOL=1, MSB first)
// and presents the extracted data field as a registered word with a valid strobe.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | CS high, SCLK high, waiting for a period trigger
// START | CS low, setup time of CLK_DIV cycles before the first SCLK fall
// SHIFT | FRAME_BITS SCLK periods, sampling SDATA on each SCLK rise
// STOP  | CS high quiet time of CLK_DIV cycles
module adc_spi_capture #(
  parameter int DATA_WIDTH    = 12,
  parameter int FRAME_BITS    = 16,
  parameter int LEAD_BITS     = 4,
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  adc_sdata,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic [DATA_WIDTH-1:0] data_adc,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [TW-1:0] TIMER_LOAD = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_BITS - 1);
  localparam logic [PW-1:0] PER_LAST   = PW'(SAMPLE_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

  state_t                state_q, state_nxt;
  logic [TW-1:0]         timer_q, timer_nxt;
  logic [BW-1:0]         bit_q, bit_nxt;
  logic                  phase_hi_q, phase_hi_nxt;
  logic [DATA_WIDTH-1:0] cap_q, cap_nxt;
  logic [PW-1:0]         per_q, per_nxt;
  logic                  cs_n_nxt, sclk_nxt, valid_nxt, busy_nxt, ovr_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;

  logic trigger;
  logic timer_tc;
  logic in_field;

  assign trigger  = enable && (per_q == '0);
  assign timer_tc = (timer_q == '0);
  assign in_field = (int'(bit_q) >= LEAD_BITS) && (int'(bit_q) < LEAD_BITS + DATA_WIDTH);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_q      <= '0;
      phase_hi_q <= 1'b0;
      cap_q      <= '0;
      per_q      <= '0;
      adc_cs_n   <= 1'b1;
      adc_sclk   <= 1'b1;
      data_adc   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      timer_q    <= timer_nxt;
      bit_q      <= bit_nxt;
      phase_hi_q <= phase_hi_nxt;
      cap_q      <= cap_nxt;
      per_q      <= per_nxt;
      adc_cs_n   <= cs_n_nxt;
      adc_sclk   <= sclk_nxt;
      data_adc   <= data_nxt;
      data_valid <= valid_nxt;
      busy       <= busy_nxt;
      overrun    <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    timer_nxt    = timer_tc ? timer_q : timer_q - 1'b1;
    bit_nxt      = bit_q;
    phase_hi_nxt = phase_hi_q;
    cap_nxt      = cap_q;
    per_nxt      = '0;
    cs_n_nxt     = adc_cs_n;
    sclk_nxt     = adc_sclk;
    data_nxt     = data_adc;
    valid_nxt    = 1'b0;
    busy_nxt     = busy;
    ovr_nxt      = overrun;

    if (!enable) begin
      // Abort: partial capture is simply never committed to data_adc.
      state_nxt    = IDLE;
      timer_nxt    = '0;
      bit_nxt      = '0;
      phase_hi_nxt = 1'b0;
      cs_n_nxt     = 1'b1;
      sclk_nxt     = 1'b1;
      busy_nxt     = 1'b0;
      ovr_nxt      = 1'b0;
    end else begin
      per_nxt = (per_q == PER_LAST) ? '0 : per_q + 1'b1;
      if (trigger && state_q != IDLE) ovr_nxt = 1'b1;

      case (state_q)
        IDLE: begin
          cs_n_nxt = 1'b1;
          sclk_nxt = 1'b1;
          if (trigger) begin
            state_nxt = START;
            cs_n_nxt  = 1'b0;
            busy_nxt  = 1'b1;
            timer_nxt = TIMER_LOAD;
          end
        end
        START: begin
          if (timer_tc) begin
            state_nxt    = SHIFT;
            sclk_nxt     = 1'b0;
            timer_nxt    = TIMER_LOAD;
            bit_nxt      = '0;
            phase_hi_nxt = 1'b0;
          end
        end
        SHIFT: begin
          if (timer_tc) begin
            timer_nxt = TIMER_LOAD;
            if (!phase_hi_q) begin
              sclk_nxt     = 1'b1;
              phase_hi_nxt = 1'b1;
              if (in_field) cap_nxt = {cap_q[DATA_WIDTH-2:0], adc_sdata};
            end else if (bit_q == LAST_BIT) begin
              // SCLK stays high here: it is already at its idle level.
              state_nxt = STOP;
              cs_n_nxt  = 1'b1;
              data_nxt  = cap_q;
              valid_nxt = 1'b1;
            end else begin
              sclk_nxt     = 1'b0;
              phase_hi_nxt = 1'b0;
              bit_nxt      = bit_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (timer_tc) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture: three instances (defaults, LEAD_BITS=0 with
// CLK_DIV=1, SAMPLE_PERIOD=100) each driven by a simple serial ADC model.
module tb_adc_spi_capture;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  en;
  logic [2:0]  sdata;
  logic [2:0]  cs_n, sclk, valid, busy, ovr;
  logic [11:0] data  [3];
  logic [15:0] frame [3];
  logic        sclk_d [3];
  int          rises [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adc_spi_capture dut_a (
    .clk(clk), .rstn(rstn), .enable(en[0]), .adc_sdata(sdata[0]),
    .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .data_adc(data[0]),
    .data_valid(valid[0]), .busy(busy[0]), .overrun(ovr[0])
  );

  adc_spi_capture #(.LEAD_BITS(0), .CLK_DIV(1)) dut_b (
    .clk(clk), .rstn(rstn), .enable(en[1]), .adc_sdata(sdata[1]),
    .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .data_adc(data[1]),
    .data_valid(valid[1]), .busy(busy[1]), .overrun(ovr[1])
  );

  adc_spi_capture #(.SAMPLE_PERIOD(100)) dut_c (
    .clk(clk), .rstn(rstn), .enable(en[2]), .adc_sdata(sdata[2]),
    .adc_cs_n(cs_n[2]), .adc_sclk(sclk[2]), .data_adc(data[2]),
    .data_valid(valid[2]), .busy(busy[2]), .overrun(ovr[2])
  );

  // ADC model: presents frame bit (15 - rises) MSB first; a new bit appears the
  // cycle after each SCLK rise, well before the next rise samples it.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (cs_n[i]) rises[i] <= 0;
      else if (sclk[i] && !sclk_d[i]) rises[i] <= rises[i] + 1;
      sclk_d[i] <= sclk[i];
    end
  end

  always_comb begin
    sdata = '0;
    for (int i = 0; i < 3; i++)
      if (rises[i] < 16) sdata[i] = frame[i][15 - rises[i]];
  end

  typedef struct {
    int          d;
    logic [15:0] frame;
    logic [11:0] exp_data;
    int          exp_lat;
    int          cdiv;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    @(negedge clk);
    en[v.d]    = 1'b0;
    frame[v.d] = v.frame;
    @(negedge clk);
    @(negedge clk);
    en[v.d] = 1'b1;
    tick();
    chk("cs_fall_at_E", cs_n[v.d], 0);
    chk("busy_at_E", busy[v.d], 1);
    k = 0;
    while (!valid[v.d] && k < 400) begin
      tick();
      k++;
    end
    chk("valid_latency", k, v.exp_lat);
    chk("data_adc", data[v.d], v.exp_data);
    chk("sclk_rises", rises[v.d], 16);
    chk("cs_rise_with_valid", cs_n[v.d], 1);
    chk("busy_in_stop", busy[v.d], 1);
    repeat (v.cdiv) tick();
    chk("busy_low_after_stop", busy[v.d], 0);
    chk("valid_one_cycle", valid[v.d], 0);
    chk("data_held", data[v.d], v.exp_data);
    @(negedge clk);
    en[v.d] = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_cs_n"}, cs_n[d], 1);
      chk({tag, "_sclk"}, sclk[d], 1);
      chk({tag, "_data"}, data[d], 0);
      chk({tag, "_valid"}, valid[d], 0);
      chk({tag, "_busy"}, busy[d], 0);
      chk({tag, "_overrun"}, ovr[d], 0);
    end
  endtask

  task automatic sclk_toggle_seq();
    @(negedge clk);
    en[1]    = 1'b0;
    frame[1] = 16'h8001;
    @(negedge clk);
    @(negedge clk);
    en[1] = 1'b1;
    tick();
    chk("div1_sclk_E", sclk[1], 1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("div1_sclk_toggle", sclk[1], (i % 2 == 0) ? 1 : 0);
    end
    @(negedge clk);
    en[1] = 1'b0;
  endtask

  task automatic overrun_and_abort_seq();
    int v1, v2, k, nv;
    v1 = -1;
    v2 = -1;
    @(negedge clk);
    frame[2] = 16'h0ABC;
    en[2]    = 1'b1;
    tick();
    chk("ovr_cs_fall", cs_n[2], 0);
    for (int t = 1; t <= 450; t++) begin
      tick();
      if (t == 99)  chk("ovr_before_2nd_trigger", ovr[2], 0);
      if (t == 100) chk("ovr_after_2nd_trigger", ovr[2], 1);
      if (valid[2]) begin
        if (v1 < 0) v1 = t;
        else if (v2 < 0) v2 = t;
      end
    end
    chk("ovr_first_valid", v1, 132);
    chk("ovr_second_valid", v2, 332);
    chk("ovr_data", data[2], 12'hABC);
    chk("ovr_sticky", ovr[2], 1);

    k = 0;
    while (rises[2] != 8 && k < 300) begin
      tick();
      k++;
    end
    chk("abort_reached_rise8", (rises[2] == 8) ? 1 : 0, 1);
    @(negedge clk);
    en[2] = 1'b0;
    tick();
    chk("abort_cs_n", cs_n[2], 1);
    chk("abort_sclk", sclk[2], 1);
    chk("abort_busy", busy[2], 0);
    chk("abort_overrun", ovr[2], 0);
    chk("abort_valid", valid[2], 0);
    chk("abort_data_kept", data[2], 12'hABC);
    nv = 0;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (valid[2]) nv++;
    end
    chk("abort_no_valid", nv, 0);
    chk("abort_data_still", data[2], 12'hABC);
  endtask

  task automatic continuous_and_reset_seq();
    int vt [3];
    int nv, k;
    nv = 0;
    @(negedge clk);
    frame[0] = 16'h0F0F;
    en[0]    = 1'b1;
    tick();
    for (int t = 1; t <= 620; t++) begin
      tick();
      if (valid[0] && nv < 3) begin
        vt[nv] = t;
        nv++;
      end
    end
    chk("cont_valid_count", nv, 3);
    chk("cont_first_valid", vt[0], 132);
    chk("cont_period_1", vt[1] - vt[0], 200);
    chk("cont_period_2", vt[2] - vt[1], 200);
    chk("cont_data", data[0], 12'hF0F);
    chk("cont_no_overrun", ovr[0], 0);

    k = 0;
    while (rises[0] != 5 && k < 300) begin
      tick();
      k++;
    end
    chk("rst_reached_shift", (rises[0] == 5) ? 1 : 0, 1);
    @(negedge clk);
    rstn = 1'b0;
    tick();
    reset_checks("midrst");
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("post_rst_cs_fall", cs_n[0], 0);
    k = 0;
    while (!valid[0] && k < 400) begin
      tick();
      k++;
    end
    chk("post_rst_latency", k, 132);
    chk("post_rst_data", data[0], 12'hF0F);
    @(negedge clk);
    en[0] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 16'h0ABC, 12'hABC, 132, 4};
    vecs[1] = '{0, 16'hF123, 12'h123, 132, 4};
    vecs[2] = '{0, 16'h5A5F, 12'hA5F, 132, 4};
    vecs[3] = '{0, 16'hFFFF, 12'hFFF, 132, 4};
    vecs[4] = '{0, 16'h0000, 12'h000, 132, 4};
    vecs[5] = '{1, 16'h8001, 12'h800, 33, 1};
    vecs[6] = '{1, 16'h0ABC, 12'h0AB, 33, 1};
    vecs[7] = '{1, 16'hC3A5, 12'hC3A, 33, 1};

    rstn = 1'b0;
    en   = '0;
    for (int i = 0; i < 3; i++) frame[i] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) tick();
    chk("idle_cs_n_no_enable", cs_n[0], 1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    sclk_toggle_seq();
    overrun_and_abort_seq();
    continuous_and_reset_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
